// File: rtl/mips_defs.sv
// Shared definitions for the pipelined MIPS control unit.
// Holds opcode and funct encodings, the 3-bit ALU control codes, the
// main-decoder ALU operation class, and the packed control bundles that
// travel through the Execute, Memory and Writeback pipeline registers.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE keeps ALUControl at 0 for instructions that do not use the ALU (j).
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
    logic       valid;
  } ctrl_e_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic valid;
  } ctrl_m_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic valid;
  } ctrl_w_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational main decoder plus ALU decoder for the Decode stage.
// Ports:
//   opcode_i  - instr[31:26]
//   funct_i   - instr[5:0]
//   ctrl_o    - Execute-stage control bundle, valid set for legal instructions
//   branch_o  - instruction is beq
//   jump_o    - instruction is j
//   illegal_o - unknown opcode, or R-type with unknown funct
// An illegal instruction forces every control to 0 so it moves down the
// pipe as a bubble.
module ctrl_decoder
  import mips_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_e_t    ctrl_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic       illegal_o
);

  ctrl_e_t    main_ctrl;
  alu_op_t    alu_op;
  logic       main_branch;
  logic       main_jump;
  logic       bad_opcode;
  logic [2:0] alu_control;
  logic       bad_funct;

  always_comb begin
    main_ctrl   = '0;
    main_branch = 1'b0;
    main_jump   = 1'b0;
    bad_opcode  = 1'b0;
    alu_op      = ALUOP_NONE;
    case (opcode_i)
      OP_RTYPE: begin
        main_ctrl.reg_write = 1'b1;
        main_ctrl.reg_dst   = 1'b1;
        alu_op              = ALUOP_FUNCT;
      end
      OP_LW: begin
        main_ctrl.reg_write  = 1'b1;
        main_ctrl.alu_src    = 1'b1;
        main_ctrl.mem_to_reg = 1'b1;
        alu_op               = ALUOP_ADD;
      end
      OP_SW: begin
        main_ctrl.alu_src   = 1'b1;
        main_ctrl.mem_write = 1'b1;
        alu_op              = ALUOP_ADD;
      end
      OP_BEQ: begin
        main_branch = 1'b1;
        alu_op      = ALUOP_SUB;
      end
      OP_ADDI: begin
        main_ctrl.reg_write = 1'b1;
        main_ctrl.alu_src   = 1'b1;
        alu_op              = ALUOP_ADD;
      end
      OP_J: begin
        main_jump = 1'b1;
      end
      default: begin
        bad_opcode = 1'b1;
      end
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    bad_funct   = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: bad_funct   = 1'b1;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    ctrl_o    = '0;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    illegal_o = bad_opcode | bad_funct;
    if (!illegal_o) begin
      ctrl_o             = main_ctrl;
      ctrl_o.alu_control = alu_control;
      ctrl_o.valid       = 1'b1;
      branch_o           = main_branch;
      jump_o             = main_jump;
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit.
// Decodes Opcode/Funct in Decode and carries the control bits through the
// E, M and W pipeline registers so each datapath stage sees the controls of
// the instruction it holds. Also counts retired (valid) instructions.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   Opcode, Funct, EqualD - Decode-stage instruction fields and compare result
//   FlushE                - load a bubble into Execute on this edge
//   *D                    - combinational Decode-stage outputs
//   *E / *M / *W          - registered stage controls
//   ValidW                - Writeback holds a real instruction
//   RetiredCount          - valid instructions that have left Writeback (wraps)
module pipe_controller
  import mips_defs::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 EqualD,
  input  logic                 FlushE,
  output logic                 BranchD,
  output logic                 JumpD,
  output logic                 PCSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 MemToRegE,
  output logic                 MemWriteE,
  output logic                 ALUSrcE,
  output logic                 RegDstE,
  output logic [2:0]           ALUControlE,
  output logic                 RegWriteM,
  output logic                 MemToRegM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemToRegW,
  output logic                 ValidW,
  output logic [CNT_WIDTH-1:0] RetiredCount
);

  ctrl_e_t              ctrl_d;
  ctrl_e_t              e_d, e_q;
  ctrl_m_t              m_d, m_q;
  ctrl_w_t              w_d, w_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  ctrl_decoder u_dec (
    .opcode_i  (Opcode),
    .funct_i   (Funct),
    .ctrl_o    (ctrl_d),
    .branch_o  (BranchD),
    .jump_o    (JumpD),
    .illegal_o (IllegalD)
  );

  assign PCSrcD = BranchD & EqualD;

  always_comb begin
    e_d = FlushE ? '0 : ctrl_d;

    m_d.reg_write  = e_q.reg_write;
    m_d.mem_to_reg = e_q.mem_to_reg;
    m_d.mem_write  = e_q.mem_write;
    m_d.valid      = e_q.valid;

    w_d.reg_write  = m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
    w_d.valid      = m_q.valid;

    // The instruction in W retires on the edge that moves it out.
    cnt_d = w_q.valid ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign RegWriteE    = e_q.reg_write;
  assign MemToRegE    = e_q.mem_to_reg;
  assign MemWriteE    = e_q.mem_write;
  assign ALUSrcE      = e_q.alu_src;
  assign RegDstE      = e_q.reg_dst;
  assign ALUControlE  = e_q.alu_control;
  assign RegWriteM    = m_q.reg_write;
  assign MemToRegM    = m_q.mem_to_reg;
  assign MemWriteM    = m_q.mem_write;
  assign RegWriteW    = w_q.reg_write;
  assign MemToRegW    = w_q.mem_to_reg;
  assign ValidW       = w_q.valid;
  assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller with a stage-by-stage scoreboard.
// Uses a narrow counter so the wrap of RetiredCount is reached.
module tb_pipe_controller;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    Opcode, Funct;
  logic          EqualD, FlushE;
  logic          BranchD, JumpD, PCSrcD, IllegalD;
  logic          RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]    ALUControlE;
  logic          RegWriteM, MemToRegM, MemWriteM;
  logic          RegWriteW, MemToRegW, ValidW;
  logic [CW-1:0] RetiredCount;

  always #5 clk = ~clk;

  pipe_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .EqualD(EqualD), .FlushE(FlushE),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .IllegalD(IllegalD),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ValidW(ValidW),
    .RetiredCount(RetiredCount)
  );

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       as;
    logic       rd;
    logic [2:0] alu;
    logic       valid;
  } e_t;

  typedef struct packed {
    logic branch;
    logic jump;
    logic illegal;
    e_t   e;
  } dec_t;

  e_t            qe[$];
  e_t            qm[$];
  e_t            qw[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_cnt;
  logic          prev_w_valid;

  // Expected decode straight from the instruction table.
  function automatic dec_t model(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: d.e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1};
          6'b100010: d.e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 1'b1};
          6'b100100: d.e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1};
          6'b100101: d.e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1};
          6'b101010: d.e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1};
          default:   d.illegal = 1'b1;
        endcase
      end
      6'b100011: d.e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1};
      6'b101011: d.e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1};
      6'b000100: begin
        d.branch = 1'b1;
        d.e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1};
      end
      6'b001000: d.e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1};
      6'b000010: begin
        d.jump = 1'b1;
        d.e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_decode();
    dec_t d;
    d = model(Opcode, Funct);
    chk("BranchD", BranchD, d.branch);
    chk("JumpD", JumpD, d.jump);
    chk("IllegalD", IllegalD, d.illegal);
    chk("PCSrcD", PCSrcD, d.branch & EqualD);
  endtask

  task automatic chk_pipe_zero(input string tag);
    chk({tag, ".E"}, {RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}, 0);
    chk({tag, ".M"}, {RegWriteM, MemToRegM, MemWriteM}, 0);
    chk({tag, ".W"}, {RegWriteW, MemToRegW, ValidW}, 0);
    chk({tag, ".RetiredCount"}, RetiredCount, 0);
  endtask

  task automatic sb_init();
    qe.delete();
    qm.delete();
    qw.delete();
    qm.push_back('0);
    qw.push_back('0);
    prev_w_valid = 1'b0;
    exp_cnt      = '0;
  endtask

  task automatic post_edge();
    e_t w, m, e;
    if (prev_w_valid) exp_cnt++;
    chk("RetiredCount", RetiredCount, exp_cnt);
    w = qw.pop_front();
    chk("W.RegWrite", RegWriteW, w.rw);
    chk("W.MemToReg", MemToRegW, w.m2r);
    chk("W.Valid", ValidW, w.valid);
    prev_w_valid = w.valid;
    m = qm.pop_front();
    chk("M.RegWrite", RegWriteM, m.rw);
    chk("M.MemToReg", MemToRegM, m.m2r);
    chk("M.MemWrite", MemWriteM, m.mw);
    qw.push_back(m);
    e = qe.pop_front();
    chk("E.RegWrite", RegWriteE, e.rw);
    chk("E.MemToReg", MemToRegE, e.m2r);
    chk("E.MemWrite", MemWriteE, e.mw);
    chk("E.ALUSrc", ALUSrcE, e.as);
    chk("E.RegDst", RegDstE, e.rd);
    chk("E.ALUControl", ALUControlE, e.alu);
    qm.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic flush);
    dec_t d;
    Opcode = op;
    Funct  = fn;
    EqualD = eq;
    FlushE = flush;
    #1;
    check_decode();
    d = model(op, fn);
    qe.push_back(flush ? e_t'('0) : d.e);
    @(posedge clk);
    #1;
    post_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(6'b111111, 6'b000000, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    Opcode = '0;
    Funct  = '0;
    EqualD = 1'b0;
    FlushE = 1'b0;
    #1;
    chk_pipe_zero("reset_async");
    for (int i = 0; i < 3; i++) begin
      Opcode = 6'($urandom_range(0, 63));
      Funct  = 6'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      check_decode();
      chk_pipe_zero("reset_hold");
    end
    reset = 1'b0;
    sb_init();

    // add alone, then drain to retirement
    issue(6'b000000, 6'b100000, 1'b0, 1'b0);
    idle(4);

    // lw, sw, slt back-to-back
    issue(6'b100011, 6'b000000, 1'b0, 1'b0);
    issue(6'b101011, 6'b000000, 1'b0, 1'b0);
    issue(6'b000000, 6'b101010, 1'b0, 1'b0);
    idle(4);

    // beq taken / not taken
    issue(6'b000100, 6'b000000, 1'b1, 1'b0);
    issue(6'b000100, 6'b000000, 1'b0, 1'b0);
    idle(4);

    // lw flushed out of Execute
    issue(6'b100011, 6'b000000, 1'b0, 1'b1);
    idle(4);

    // illegal opcode / illegal funct, each followed by addi
    issue(6'b111111, 6'b100000, 1'b0, 1'b0);
    issue(6'b001000, 6'b000000, 1'b0, 1'b0);
    issue(6'b000000, 6'b000000, 1'b0, 1'b0);
    issue(6'b001000, 6'b000000, 1'b0, 1'b0);

    // remaining funct codes, j, and a flush in the middle of a stream
    issue(6'b000000, 6'b100010, 1'b0, 1'b0);
    issue(6'b000000, 6'b100100, 1'b0, 1'b0);
    issue(6'b000000, 6'b100101, 1'b0, 1'b0);
    issue(6'b000010, 6'b000000, 1'b1, 1'b0);
    issue(6'b101011, 6'b000000, 1'b0, 1'b1);
    issue(6'b000000, 6'b100000, 1'b0, 1'b0);
    idle(4);

    // reset asserted between edges with work in flight
    issue(6'b100011, 6'b000000, 1'b0, 1'b0);
    issue(6'b001000, 6'b000000, 1'b0, 1'b0);
    issue(6'b000000, 6'b100000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_pipe_zero("reset_mid");
    check_decode();
    @(posedge clk);
    #1;
    chk_pipe_zero("reset_mid_edge");
    reset = 1'b0;
    sb_init();

    issue(6'b000000, 6'b100000, 1'b0, 1'b0);
    issue(6'b100011, 6'b000000, 1'b0, 1'b0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
